// File: rtl/exp_filter_pkg.sv
// Shared definitions for the exponential-filter frame sequencer:
// FSM state encoding and default geometry.
package exp_filter_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_WRITE   = 3'd2,
      S_CAPTURE = 3'd3,
      S_SEND    = 3'd4
   } state_t;

   localparam int DEF_NUM_BINS = 40;
   localparam int DEF_DW       = 8;

endpackage : exp_filter_pkg

// File: rtl/exp_filter_sequencer.sv
// Frame-level controller: walks every spectrum bin through RAM read, filter
// update and a valid/ready output stream, four cycles per bin when unstalled.
module exp_filter_sequencer
   import exp_filter_pkg::*;
#(
   parameter int NUM_BINS = DEF_NUM_BINS,
   parameter int AW       = 8,
   parameter int DW       = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [AW-1:0] flt_addr,
   output logic [DW-1:0] flt_in,
   output logic          flt_write,
   input  logic [DW-1:0] flt_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_bin,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          frame_done,
   output logic          overrun,
   input  logic          overrun_clr
);

   localparam logic [AW-1:0] LAST_BIN = AW'(NUM_BINS - 1);

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_cnt;
   logic [DW-1:0] r_flt_in;
   logic          w_handshake;
   logic          w_is_last;

   // out_valid is always high in SEND, so the state alone qualifies the handshake.
   assign w_handshake = (r_state == S_SEND) && out_ready;
   assign w_is_last   = (r_cnt == LAST_BIN);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (frame_start) w_next = S_READ;
         S_READ:    w_next = S_WRITE;
         S_WRITE:   w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_SEND;
         S_SEND:    if (w_handshake) w_next = w_is_last ? S_IDLE : S_READ;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_flt_in   <= '0;
         out_valid  <= 1'b0;
         out_bin    <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= w_handshake && w_is_last;

         if (r_state == S_IDLE && frame_start) r_cnt <= '0;
         else if (w_handshake && !w_is_last)   r_cnt <= r_cnt + 1'b1;

         if (r_state == S_WRITE) r_flt_in <= rd_data;

         if (r_state == S_CAPTURE) begin
            out_valid <= 1'b1;
            out_bin   <= r_cnt;
            out_data  <= flt_out;
            out_last  <= w_is_last;
         end else if (w_handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         // A start request while a frame is in flight is dropped but flagged.
         if (frame_start && r_state != S_IDLE) overrun <= 1'b1;
         else if (overrun_clr)                 overrun <= 1'b0;
      end
   end

   assign rd_addr   = r_cnt;
   assign flt_addr  = r_cnt;
   assign flt_write = (r_state == S_WRITE);
   assign flt_in    = flt_write ? rd_data : r_flt_in;
   assign busy      = (r_state != S_IDLE);

endmodule : exp_filter_sequencer

// File: tb/tb_exp_filter_sequencer.sv
// Directed bench for exp_filter_sequencer with a RAM model, a registered
// filter model and a negedge monitor logging filter writes and handshakes.
module tb_exp_filter_sequencer;

   localparam int NB = 40;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LOG_DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          frame_start = 1'b0;
   logic          out_ready = 1'b1;
   logic          overrun_clr = 1'b0;
   logic [AW-1:0] rd_addr, flt_addr, out_bin;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] flt_out = '0;
   logic [DW-1:0] flt_in, out_data;
   logic          flt_write, out_valid, out_last, busy, frame_done, overrun;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exp_filter_sequencer #(.NUM_BINS(NB), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .flt_addr(flt_addr), .flt_in(flt_in), .flt_write(flt_write), .flt_out(flt_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
      .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   // Spectrum RAM holds i+1 at address i, one-cycle read latency.
   logic [DW-1:0] ram [256];
   always @(posedge clk) rd_data <= ram[rd_addr];

   // Filter stand-in: bin 7 returns 0xAB, every other bin returns raw + 0x10.
   always @(posedge clk)
      if (flt_write) flt_out <= (flt_addr == 8'd7) ? 8'hAB : flt_in + 8'h10;

   logic [7:0] wr_addr [LOG_DEPTH];
   logic [7:0] wr_data [LOG_DEPTH];
   int         wr_cyc  [LOG_DEPTH];
   logic [7:0] hs_bin  [LOG_DEPTH];
   logic [7:0] hs_data [LOG_DEPTH];
   logic       hs_last [LOG_DEPTH];
   int         hs_cyc  [LOG_DEPTH];
   int         n_wr = 0;
   int         n_hs = 0;

   always @(negedge clk) begin
      if (flt_write && n_wr < LOG_DEPTH) begin
         wr_addr[n_wr] <= flt_addr;
         wr_data[n_wr] <= flt_in;
         wr_cyc[n_wr]  <= cyc;
         n_wr          <= n_wr + 1;
      end
      if (out_valid && out_ready && n_hs < LOG_DEPTH) begin
         hs_bin[n_hs]  <= out_bin;
         hs_data[n_hs] <= out_data;
         hs_last[n_hs] <= out_last;
         hs_cyc[n_hs]  <= cyc;
         n_hs          <= n_hs + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_out(input int i);
      return (i == 7) ? 8'hAB : 8'(i + 1 + 16);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(output int s);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      s = cyc;
   endtask

   task automatic wait_done(input string tag, output int d);
      bit found = 1'b0;
      d = -1;
      for (int k = 0; k < 2000 && !found; k++) begin
         tick();
         if (frame_done) begin
            found = 1'b1;
            d = cyc;
         end
      end
      check({tag, " frame_done seen"}, 32'(found), 32'd1);
   endtask

   task automatic wait_write(input string tag, input logic [7:0] bin);
      bit found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         if (flt_write && flt_addr == bin) found = 1'b1;
      end
      check({tag, " write reached"}, 32'(found), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " out_valid"},  32'(out_valid),  32'd0);
      check({tag, " busy"},       32'(busy),       32'd0);
      check({tag, " flt_write"},  32'(flt_write),  32'd0);
      check({tag, " rd_addr"},    32'(rd_addr),    32'd0);
      check({tag, " flt_addr"},   32'(flt_addr),   32'd0);
      check({tag, " flt_in"},     32'(flt_in),     32'd0);
      check({tag, " out_bin"},    32'(out_bin),    32'd0);
      check({tag, " out_data"},   32'(out_data),   32'd0);
      check({tag, " out_last"},   32'(out_last),   32'd0);
      check({tag, " frame_done"}, 32'(frame_done), 32'd0);
      check({tag, " overrun"},    32'(overrun),    32'd0);
   endtask

   task automatic check_frame(input string tag, input int wb, input int hb);
      for (int i = 0; i < NB; i++) begin
         check($sformatf("%s wr_addr[%0d]", tag, i), 32'(wr_addr[wb+i]), 32'(i));
         check($sformatf("%s wr_data[%0d]", tag, i), 32'(wr_data[wb+i]), 32'(i + 1));
         check($sformatf("%s out_bin[%0d]", tag, i), 32'(hs_bin[hb+i]), 32'(i));
         check($sformatf("%s out_data[%0d]", tag, i), 32'(hs_data[hb+i]), 32'(exp_out(i)));
         check($sformatf("%s out_last[%0d]", tag, i), 32'(hs_last[hb+i]), 32'(i == NB - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s, d, s2, d2, wb, hb;

      for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);

      // Reset state
      #2 rst_n = 1'b0;
      #20;
      check_zero("reset");
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle busy", 32'(busy), 32'd0);

      // Frame 1: out_ready tied high
      wb = n_wr; hb = n_hs;
      start_frame(s);
      check("f1 busy after start", 32'(busy), 32'd1);
      wait_done("f1", d);
      check("f1 start-to-done cycles", 32'(d - s), 32'd160);
      check("f1 busy at done", 32'(busy), 32'd0);
      check("f1 out_valid at done", 32'(out_valid), 32'd0);
      tick();
      check("f1 frame_done one cycle", 32'(frame_done), 32'd0);
      check("f1 write count", 32'(n_wr - wb), 32'd40);
      check("f1 handshake count", 32'(n_hs - hb), 32'd40);
      check_frame("f1", wb, hb);
      check("f1 bin7 write-to-send", 32'(hs_cyc[hb+7] - wr_cyc[wb+7]), 32'd2);

      // Frame 2: out_ready low for 10 SEND cycles at bin 5
      wb = n_wr; hb = n_hs;
      start_frame(s);
      wait_write("bp", 8'd5);
      tick();
      out_ready = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("bp stall%0d out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp stall%0d out_bin", k), 32'(out_bin), 32'd5);
         check($sformatf("bp stall%0d out_data", k), 32'(out_data), 32'h16);
         check($sformatf("bp stall%0d flt_write", k), 32'(flt_write), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done("bp", d);
      check("bp start-to-done cycles", 32'(d - s), 32'd170);
      check("bp write count", 32'(n_wr - wb), 32'd40);
      check("bp handshake count", 32'(n_hs - hb), 32'd40);
      check_frame("bp", wb, hb);

      // Frame 3: frame_start at cycle 50 is ignored and flags overrun
      wb = n_wr; hb = n_hs;
      start_frame(s);
      while (cyc < s + 49) tick();
      check("ov before", 32'(overrun), 32'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("ov set", 32'(overrun), 32'd1);
      check("ov busy", 32'(busy), 32'd1);
      wait_done("ov", d);
      check("ov start-to-done cycles", 32'(d - s), 32'd160);
      check("ov write count", 32'(n_wr - wb), 32'd40);
      check_frame("ov", wb, hb);
      repeat (3) tick();
      check("ov no extra frame", 32'(busy), 32'd0);
      check("ov sticky", 32'(overrun), 32'd1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("ov cleared", 32'(overrun), 32'd0);

      // Frame 4: set beats clear, then reset mid-frame at bin 20
      start_frame(s);
      repeat (10) tick();
      frame_start = 1'b1;
      overrun_clr = 1'b1;
      tick();
      frame_start = 1'b0;
      overrun_clr = 1'b0;
      check("rst set beats clear", 32'(overrun), 32'd1);
      wait_write("rst", 8'd20);
      #2 rst_n = 1'b0;
      #1;
      check_zero("rst async");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("rst not resumed busy", 32'(busy), 32'd0);
      check("rst not resumed valid", 32'(out_valid), 32'd0);
      wb = n_wr; hb = n_hs;
      start_frame(s);
      wait_done("post_rst", d);
      check("post_rst start-to-done cycles", 32'(d - s), 32'd160);
      check("post_rst write count", 32'(n_wr - wb), 32'd40);
      check_frame("post_rst", wb, hb);

      // Frames 5 and 6: second start lands in the frame_done cycle
      repeat (2) tick();
      wb = n_wr; hb = n_hs;
      start_frame(s);
      wait_done("b2b_a", d);
      start_frame(s2);
      check("b2b start after done", 32'(s2 - d), 32'd1);
      check("b2b no overrun", 32'(overrun), 32'd0);
      check("b2b busy", 32'(busy), 32'd1);
      wait_done("b2b_b", d2);
      check("b2b_a start-to-done cycles", 32'(d - s), 32'd160);
      check("b2b_b start-to-done cycles", 32'(d2 - s2), 32'd160);
      check("b2b write count", 32'(n_wr - wb), 32'd80);
      check("b2b handshake count", 32'(n_hs - hb), 32'd80);
      check_frame("b2b_a", wb, hb);
      check_frame("b2b_b", wb + NB, hb + NB);
      check("b2b end overrun", 32'(overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_exp_filter_sequencer
